// File: rtl/bp_trace_decoder.sv
// Nexus trace receive decoder: rebuilds the committed-PC stream with absolute cycle numbers.
// Optional real-time replay pacing is enabled by defining NEXUS_DEC_REPLAY_EN.
`ifndef NEXUS_MCODE_DIRECT_BRANCH
`define NEXUS_MCODE_DIRECT_BRANCH 3
`endif
`ifndef NEXUS_MCODE_COMPRESSED
`define NEXUS_MCODE_COMPRESSED 33
`endif

module bp_trace_decoder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned MCODE_W = 6,
  parameter int unsigned CYC_W   = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               trace_valid_i,
  output logic               trace_ready_o,
  input  logic [MCODE_W-1:0] trace_mcode_i,
  input  logic [TS_W-1:0]    trace_timestamp_i,
  input  logic [ADDR_W-1:0]  trace_addr_i,
  output logic               pc_valid_o,
  input  logic               pc_ready_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [CYC_W-1:0]   cycle_o,
  output logic               synced_o,
  output logic               err_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int unsigned CW1 = CYC_W + 1;
  localparam logic [MCODE_W-1:0] MCODE_DIRECT = MCODE_W'(`NEXUS_MCODE_DIRECT_BRANCH);
  localparam logic [MCODE_W-1:0] MCODE_COMP   = MCODE_W'(`NEXUS_MCODE_COMPRESSED);

`ifdef NEXUS_DEC_REPLAY_EN
  typedef enum logic [1:0] {UNSYNC, SYNC, WAIT} state_t;
`else
  typedef enum logic [0:0] {UNSYNC, SYNC} state_t;
`endif

  state_t state_q, state_d;

  logic [ADDR_W-1:0] last_pc;
  logic [CYC_W-1:0]  cycle_acc;
  logic [CW1-1:0]    cyc_wide;
  logic [CYC_W-1:0]  cyc_sum;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] load_pc;
  logic [CYC_W-1:0]  load_cyc;
  logic              is_direct, is_comp;
  logic              out_free, accept, pop;
  logic              valid_evt, drop, load_out;

`ifdef NEXUS_DEC_REPLAY_EN
  logic [TS_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0] pend_pc;
  logic [CYC_W-1:0]  pend_cyc;
  logic              start_wait;
`endif

  assign is_direct = (trace_mcode_i == MCODE_DIRECT);
  assign is_comp   = (trace_mcode_i == MCODE_COMP);
  assign out_free  = !pc_valid_o || pc_ready_i;
  assign pop       = pc_valid_o && pc_ready_i;

`ifdef NEXUS_DEC_REPLAY_EN
  assign trace_ready_o = (state_q != WAIT) && out_free;
`else
  assign trace_ready_o = out_free;
`endif

  assign accept = trace_valid_i && trace_ready_o;

  // A compressed offset only means something once a base PC exists.
  assign valid_evt = accept && (is_direct || (is_comp && state_q == SYNC));
  assign drop      = accept && !valid_evt;

  // Offset width equals the PC width, so the sign extension is the identity and the add wraps.
  assign new_pc   = is_direct ? trace_addr_i : last_pc + trace_addr_i;
  assign cyc_wide = {1'b0, cycle_acc} + CW1'(trace_timestamp_i);
  assign cyc_sum  = cyc_wide[CYC_W] ? '1 : cyc_wide[CYC_W-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= UNSYNC;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    load_pc  = new_pc;
    load_cyc = cyc_sum;
`ifdef NEXUS_DEC_REPLAY_EN
    start_wait = 1'b0;
`endif
    case (state_q)
      UNSYNC, SYNC: begin
        if (valid_evt) begin
          state_d = SYNC;
`ifdef NEXUS_DEC_REPLAY_EN
          if (trace_timestamp_i != '0) begin
            state_d    = WAIT;
            start_wait = 1'b1;
          end else begin
            load_out = 1'b1;
          end
`else
          load_out = 1'b1;
`endif
        end
      end
`ifdef NEXUS_DEC_REPLAY_EN
      WAIT: begin
        load_pc  = pend_pc;
        load_cyc = pend_cyc;
        if (wait_cnt == '0 && out_free) begin
          load_out = 1'b1;
          state_d  = SYNC;
        end
      end
`endif
      default: state_d = UNSYNC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_pc    <= '0;
      cycle_acc  <= '0;
      pc_valid_o <= 1'b0;
      pc_o       <= '0;
      cycle_o    <= '0;
      synced_o   <= 1'b0;
      err_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (accept)    cycle_acc <= cyc_sum;
      if (valid_evt) begin
        last_pc  <= new_pc;
        synced_o <= 1'b1;
      end
      if (drop) begin
        err_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
      if (load_out) begin
        pc_valid_o <= 1'b1;
        pc_o       <= load_pc;
        cycle_o    <= load_cyc;
      end else if (pop) begin
        pc_valid_o <= 1'b0;
      end
    end
  end

`ifdef NEXUS_DEC_REPLAY_EN
  // Countdown starts at T-1 so the event lands T+1 cycles after its packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt <= '0;
      pend_pc  <= '0;
      pend_cyc <= '0;
    end else if (start_wait) begin
      wait_cnt <= trace_timestamp_i - TS_W'(1);
      pend_pc  <= new_pc;
      pend_cyc <= cyc_sum;
    end else if (state_q == WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - TS_W'(1);
    end
  end
`endif

endmodule

// File: doc/bp_trace_decoder.md
Name: bp_trace_decoder

Overview:
- Receive end of the Nexus trace stream: consumes packets from the trace encoder (via the trace FIFO) and reconstructs the committed-PC stream with absolute cycle numbers.
- Sits on the host/analysis side of the trace path and feeds the checker/scoreboard.
- Decodes two message codes, NEXUS_MCODE_DIRECT_BRANCH and NEXUS_MCODE_COMPRESSED, both taken from bp_nexus_defines.svh.

Parameters:
- ADDR_W, 32, PC and packet address width.
- TS_W, 16, packet timestamp (delay) field width.
- MCODE_W, 6, message-code field width.
- CYC_W, 32, width of the reconstructed absolute cycle count.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- trace_valid_i  in  1  input packet valid
- trace_ready_o  out  1  decoder can accept a packet
- trace_mcode_i  in  MCODE_W  packet message code
- trace_timestamp_i  in  TS_W  cycles since the previous packet
- trace_addr_i  in  ADDR_W  full target (DIRECT_BRANCH) or signed byte offset (COMPRESSED)
- pc_valid_o  out  1  reconstructed event valid
- pc_ready_i  in  1  consumer accepts the event
- pc_o  out  ADDR_W  reconstructed PC
- cycle_o  out  CYC_W  absolute cycle of the event
- synced_o  out  1  base PC established
- err_o  out  1  sticky error: unknown mcode, or a compressed packet received while unsynced
- drop_cnt_o  out  16  count of dropped packets, saturating

Behaviour:
- Reset (synchronous, active-high):
  - pc_valid_o=0, pc_o=0, cycle_o=0, synced_o=0, err_o=0, drop_cnt_o=0.
  - Internal last_pc=0, cycle_acc=0, FSM=UNSYNC.
  - trace_ready_o=1 in the cycle after reset deasserts.
  - Reset mid-operation discards any held output and any pending wait.
- Handshakes:
  - An input packet is accepted when trace_valid_i && trace_ready_o.
  - An output event transfers when pc_valid_o && pc_ready_i.
  - Output register is a single entry: trace_ready_o = (FSM!=WAIT) && (!pc_valid_o || pc_ready_i).
  - Back-to-back throughput is 1 packet/cycle.
- Arithmetic:
  - cycle_acc += trace_timestamp_i, zero-extended, saturating at all-ones of CYC_W.
  - Compressed: new_pc = last_pc + sign_extend(trace_addr_i), modulo 2^ADDR_W (wraps silently).
  - Direct: new_pc = trace_addr_i.
- FSM states UNSYNC, SYNC, WAIT (WAIT exists only with the optional feature).
- UNSYNC:
  - DIRECT_BRANCH accepted: last_pc<=addr; output registered next cycle; synced_o<=1; go to SYNC.
  - COMPRESSED accepted: dropped, drop_cnt++, err_o<=1. cycle_acc is still updated.
  - Unknown mcode: dropped, drop_cnt++, err_o<=1.
- SYNC:
  - DIRECT_BRANCH or COMPRESSED accepted: last_pc<=new_pc; output pc_o=new_pc, cycle_o=updated cycle_acc, pc_valid_o=1 on the next cycle (latency 1).
  - Unknown mcode: dropped, drop_cnt++, err_o<=1; stay in SYNC.
- Output hold: pc_valid_o holds, with pc_o and cycle_o stable, until pc_ready_i.
- Simultaneous output pop and input accept in the same cycle: the new event replaces the old with no bubble.
- err_o clears only on reset.

Optional Feature:
- Macro: NEXUS_DEC_REPLAY_EN.
- Enabled: real-time replay.
  - In SYNC, an accepted packet with timestamp T>0 enters WAIT with countdown T-1.
  - The event is presented after T+1 cycles, so output spacing matches the original commit timing.
  - T=0 presents the event next cycle, as without the macro.
  - trace_ready_o=0 while in WAIT; the FSM returns to SYNC when the event is loaded.
  - An UNSYNC-state DIRECT_BRANCH also waits T cycles.
- Disabled: WAIT state, countdown counter and related logic are absent; latency is always 1.

Test Plan:
- Reset then DIRECT_BRANCH addr=0x1000, ts=5 -> next cycle pc_o=0x1000, cycle_o=5, synced_o=1, err_o=0.
- After the above, COMPRESSED addr=16, ts=3 -> pc_o=0x1010, cycle_o=8. Then DIRECT_BRANCH 0x80000000, ts=6 -> pc_o=0x80000000, cycle_o=14.
- COMPRESSED addr=16 before any DIRECT_BRANCH -> no pc_valid_o, drop_cnt_o=1, err_o=1, synced_o=0.
- Synced at last_pc=0x1010, COMPRESSED addr=0xFFFFFFF0 (-16) -> pc_o=0x1000. From last_pc=0xFFFFFFFC, offset +8 -> pc_o=0x00000004.
- Hold pc_ready_i=0 with 3 back-to-back packets offered -> first event held stable, trace_ready_o=0, no loss; release pc_ready_i -> events emerge in order, one per cycle.
- With NEXUS_DEC_REPLAY_EN: packets ts=3 then ts=6 -> consecutive pc_valid_o rising edges 7 cycles apart (6+1); trace_ready_o low throughout each WAIT.
